// File: rtl/serial_pattern_detector_pkg.sv
// Shared defaults for the serial pattern detector: pattern geometry and counter width.
package serial_pattern_detector_pkg;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
  localparam int         DEF_CNT_W   = 8;

endpackage

// File: rtl/serial_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         areset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (areset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_pattern_detector.sv
// Detects a PAT_W-bit pattern in an enabled serial stream and publishes per-frame match totals.
module serial_pattern_detector
  import serial_pattern_detector_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             areset,
  input  logic             serin,
  input  logic             enable,
  input  logic             frame_end,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] frame_count,
  output logic             frame_valid
);

  localparam int                FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  hist_q, hist_d, nxt;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  frame_count_q, frame_count_d;
  logic              detect_q, frame_valid_q;
  logic              hit;

  always_comb begin
    nxt    = {hist_q[PAT_W-2:0], serin};
    hit    = enable && (fill_q == FILL_MAX) && (nxt == PATTERN);
    hist_d = enable ? nxt : hist_q;
    fill_d = fill_q;
    if (hit) begin
      fill_d = OVERLAP ? FILL_MAX : '0;
    end else if (enable && (fill_q != FILL_MAX)) begin
      fill_d = fill_q + FILL_W'(1);
    end
    // A hit coinciding with frame_end belongs to the frame being closed.
    frame_count_d = frame_count_q;
    if (frame_end) begin
      frame_count_d = (hit && (match_count != '1)) ? match_count + CNT_W'(1) : match_count;
    end
  end

  always_ff @(posedge clock) begin
    if (areset) begin
      hist_q        <= '0;
      fill_q        <= '0;
      detect_q      <= 1'b0;
      frame_count_q <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      detect_q      <= hit;
      frame_count_q <= frame_count_d;
      frame_valid_q <= frame_end;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clock  (clock),
    .areset (areset),
    .inc    (hit),
    .clr    (frame_end),
    .q      (match_count)
  );

  assign detect      = detect_q;
  assign frame_count = frame_count_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: overlapping and non-overlapping instances against a reference model.
module tb_serial_pattern_detector;

  localparam int PW   = 4;
  localparam int PAT  = 11;   // 4'b1011
  localparam int CMAX = 255;

  logic       clock = 1'b0;
  logic       areset, serin, enable, frame_end;
  logic       det0, det1, fv0, fv1;
  logic [7:0] mc0, mc1, fc0, fc1;

  always #5 clock = ~clock;

  serial_pattern_detector #(.OVERLAP(1'b1)) dut_ov (
    .clock (clock), .areset (areset), .serin (serin), .enable (enable),
    .frame_end (frame_end), .detect (det0), .match_count (mc0),
    .frame_count (fc0), .frame_valid (fv0)
  );

  serial_pattern_detector #(.OVERLAP(1'b0)) dut_no (
    .clock (clock), .areset (areset), .serin (serin), .enable (enable),
    .frame_end (frame_end), .detect (det1), .match_count (mc1),
    .frame_count (fc1), .frame_valid (fv1)
  );

  int n_pass  = 0;
  int n_total = 0;
  int dets0   = 0;
  int dets1   = 0;

  // Reference state; index 0 models OVERLAP=1, index 1 models OVERLAP=0.
  int m_nb [2];   // bits received since reset / since last non-overlapping match
  int m_vl [2];   // value of the last PW bits received
  int m_mc [2];
  int m_fc [2];
  bit m_det[2];
  bit m_fv [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic void model_step(input bit r, input bit e, input bit s, input bit f);
    bit h;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_nb[i] = 0; m_vl[i] = 0; m_mc[i] = 0; m_fc[i] = 0;
        m_det[i] = 1'b0; m_fv[i] = 1'b0;
      end else begin
        h = 1'b0;
        if (e) begin
          m_nb[i] = (m_nb[i] < 64) ? m_nb[i] + 1 : 64;
          m_vl[i] = (m_vl[i] * 2 + int'(s)) % (1 << PW);
          h = (m_nb[i] >= PW) && (m_vl[i] == PAT);
          if (h && i == 1) m_nb[i] = 0;
        end
        m_det[i] = h;
        if (f) begin
          m_fc[i] = (m_mc[i] + int'(h) > CMAX) ? CMAX : m_mc[i] + int'(h);
          m_mc[i] = 0;
          m_fv[i] = 1'b1;
        end else begin
          m_fv[i] = 1'b0;
          m_mc[i] = (m_mc[i] + int'(h) > CMAX) ? CMAX : m_mc[i] + int'(h);
        end
      end
    end
  endfunction

  task automatic check_all();
    chk("detect_ov",      32'(det0), 32'(m_det[0]));
    chk("match_count_ov", 32'(mc0),  32'(m_mc[0]));
    chk("frame_count_ov", 32'(fc0),  32'(m_fc[0]));
    chk("frame_valid_ov", 32'(fv0),  32'(m_fv[0]));
    chk("detect_no",      32'(det1), 32'(m_det[1]));
    chk("match_count_no", 32'(mc1),  32'(m_mc[1]));
    chk("frame_count_no", 32'(fc1),  32'(m_fc[1]));
    chk("frame_valid_no", 32'(fv1),  32'(m_fv[1]));
    if (det0 === 1'b1) dets0++;
    if (det1 === 1'b1) dets1++;
  endtask

  task automatic cycle(input bit r, input bit e, input bit s, input bit f);
    areset = r; enable = e; serin = s; frame_end = f;
    @(posedge clock);
    model_step(r, e, s, f);
    #1;
    check_all();
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) cycle(1'b0, 1'b1, bits[k], 1'b0);
  endtask

  initial begin
    // 1: reset held two clocks, then "011" gives no detect
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_reset_detect", 32'(det0), 32'd0);
    chk("t1_reset_mc",     32'(mc0),  32'd0);
    chk("t1_reset_fc",     32'(fc0),  32'd0);
    chk("t1_reset_fv",     32'(fv0),  32'd0);
    dets0 = 0; dets1 = 0;
    send_bits(16'b011, 3);
    chk("t1_no_detect", 32'(dets0 + dets1), 32'd0);

    // 2/3: stream 1011011 -> overlap sees 2 matches, non-overlap sees 1
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    dets0 = 0; dets1 = 0;
    send_bits(16'b1011011, 7);
    chk("t2_mc_ov",   32'(mc0),   32'd2);
    chk("t2_dets_ov", 32'(dets0), 32'd2);
    chk("t3_mc_no",   32'(mc1),   32'd1);
    chk("t3_dets_no", 32'(dets1), 32'd1);

    // 4: bits 1,0,1,1 separated by disabled cycles with serin toggling
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    dets0 = 0;
    for (int k = 3; k >= 0; k--) begin
      logic [3:0] b4;
      b4 = 4'b1011;
      cycle(1'b0, 1'b1, b4[k], 1'b0);
      if (k == 0) chk("t4_detect_after_bit4", 32'(det0), 32'd1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("t4_dets", 32'(dets0), 32'd1);

    // 5: three matches, then a hit in the frame_end cycle
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'b1011011011, 10);
    chk("t5_mc_before", 32'(mc0), 32'd3);
    send_bits(16'b01, 2);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_fc",    32'(fc0), 32'd4);
    chk("t5_fv",    32'(fv0), 32'd1);
    chk("t5_mc",    32'(mc0), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_fv_drop", 32'(fv0), 32'd0);
    chk("t5_fc_hold", 32'(fc0), 32'd4);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_empty_frame_fc", 32'(fc0), 32'd0);
    chk("t5_empty_frame_fv", 32'(fv0), 32'd1);

    // 6: 300 matches saturate, then reset mid-pattern discards history
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) send_bits(16'b1011, 4);
    chk("t6_sat_ov", 32'(mc0), 32'd255);
    chk("t6_sat_no", 32'(mc1), 32'd255);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_fc_sat", 32'(fc0), 32'd255);
    send_bits(16'b101, 3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    dets0 = 0; dets1 = 0;
    send_bits(16'b101, 3);
    chk("t6_no_early_detect", 32'(dets0 + dets1), 32'd0);
    send_bits(16'b1, 1);
    chk("t6_fresh_detect", 32'(det0), 32'd1);

    // Randomized traffic against the reference model
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0),
            1'($urandom_range(1)), ($urandom_range(15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
